// File: rtl/alu_pkg.sv
// Shared width default and ALUoper encodings for the execute-stage ALU.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder: A+B when sub=0, A+~B+1 when sub=1; raw carry and signed overflow.
module alu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   always_comb begin
      b_eff = sub ? ~B : B;
      full  = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      sum   = full[WIDTH-1:0];
      carry = full[WIDTH];
      // Operands of equal sign (after inversion) producing a result of the other sign.
      ovf   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
   end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: op mux over one shared add/sub, flags, one-cycle latency.
// Optional ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Adat,
   input  logic [WIDTH-1:0] Bdat,
   input  logic [2:0]       ALUoper,
   output logic [WIDTH-1:0] Result,
   output logic             zero,
   output logic             carryout,
   output logic             overflow
);

   logic             sub;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;

   logic [WIDTH-1:0] result_d, result_q;
   logic             zero_d, zero_q;
   logic             carry_d, carry_q;
   logic             ovf_d, ovf_q;

   assign sub = (ALUoper != OP_ADD);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .A     (Adat),
      .B     (Bdat),
      .sub   (sub),
      .sum   (sum),
      .carry (carry),
      .ovf   (ovf)
   );

   always_comb begin
      result_d = '0;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
      case (ALUoper)
         OP_AND: result_d = Adat & Bdat;
         OP_OR:  result_d = Adat | Bdat;
         OP_XOR: result_d = Adat ^ Bdat;
         OP_NOR: result_d = ~(Adat | Bdat);
         OP_ADD, OP_SUB: begin
            result_d = sum;
            carry_d  = carry;
            ovf_d    = ovf;
`ifdef ALU_SAT_EN
            // Sign of A gives the direction of the overflow for both ADD and SUB.
            if (ovf)
               result_d = Adat[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
`endif
         end
         OP_SLTU: begin
            result_d = {{(WIDTH-1){1'b0}}, ~carry};
            carry_d  = carry;
         end
         OP_SLT: begin
            result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            carry_d  = carry;
         end
         default: ;
      endcase
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign Result   = result_q;
   assign zero     = zero_q;
   assign carryout = carry_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table plus random ops, checked through an expected-result queue.
module tb_alu;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        o;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [2:0] op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] Adat = '0;
   logic [31:0] Bdat = '0;
   logic [2:0]  ALUoper = 3'b000;
   logic [31:0] Result;
   logic        zero, carryout, overflow;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];
   vec_t vecs[$];

   alu dut (
      .clk      (clk),
      .rst      (rst),
      .Adat     (Adat),
      .Bdat     (Bdat),
      .ALUoper  (ALUoper),
      .Result   (Result),
      .zero     (zero),
      .carryout (carryout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res,
                               input logic z, input logic c, input logic o);
      vec_t v;
      v.rst = r; v.op = op; v.a = a; v.b = b;
      v.e.res = res; v.e.z = z; v.e.c = c; v.e.o = o;
      return v;
   endfunction

   // Independent reference using wide signed/unsigned arithmetic.
   function automatic exp_t model(input logic r, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint sa, sb_, tru;
      logic [63:0] ua, ub, usum;
      sa = longint'($signed(a));
      sb_ = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      e = '0;
      if (r) begin
         e.z = 1'b1;
         return e;
      end
      case (op)
         3'b000: e.res = a & b;
         3'b001: e.res = a | b;
         3'b011: e.res = a ^ b;
         3'b100: e.res = ~(a | b);
         3'b010: begin
            usum = ua + ub;
            tru = sa + sb_;
            e.res = usum[31:0];
            e.c = usum[32];
            e.o = (tru > 64'sd2147483647) || (tru < -64'sd2147483648);
         end
         3'b110: begin
            tru = sa - sb_;
            e.res = a - b;
            e.c = (a >= b);
            e.o = (tru > 64'sd2147483647) || (tru < -64'sd2147483648);
         end
         3'b101: begin e.res = {31'b0, a < b}; e.c = (a >= b); end
         default: begin e.res = {31'b0, $signed(a) < $signed(b)}; e.c = (a >= b); end
      endcase
`ifdef ALU_SAT_EN
      if ((op == 3'b010 || op == 3'b110) && e.o)
         e.res = (tru > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
      e.z = (e.res == 32'h0);
      return e;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step%0d: got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic compare(input int idx);
      exp_t e;
      e = sb.pop_front();
      chk("result",   idx, Result, e.res);
      chk("zero",     idx, {31'b0, zero}, {31'b0, e.z});
      chk("carryout", idx, {31'b0, carryout}, {31'b0, e.c});
      chk("overflow", idx, {31'b0, overflow}, {31'b0, e.o});
   endtask

   task automatic step(input int idx, input vec_t v);
      @(negedge clk);
      if (sb.size() > 0) compare(idx);
      rst = v.rst; ALUoper = v.op; Adat = v.a; Bdat = v.b;
      sb.push_back(v.e);
   endtask

   initial begin
      int n;
      vec_t v;
      // reset held two cycles with an ADD pending, then released
      vecs.push_back(mk(1, 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0));
      vecs.push_back(mk(1, 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0));
      vecs.push_back(mk(0, 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0));
`ifdef ALU_SAT_EN
      vecs.push_back(mk(0, 3'b010, 32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF, 0, 0, 1));
`else
      vecs.push_back(mk(0, 3'b010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1));
`endif
      vecs.push_back(mk(0, 3'b110, 32'h5, 32'h5, 32'h0, 1, 1, 0));
`ifdef ALU_SAT_EN
      vecs.push_back(mk(0, 3'b110, 32'h80000000, 32'h1, 32'h80000000, 0, 1, 1));
`else
      vecs.push_back(mk(0, 3'b110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 1));
`endif
      vecs.push_back(mk(0, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 1, 0));
      vecs.push_back(mk(0, 3'b101, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0));
      vecs.push_back(mk(0, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h1, 0, 1, 0));
      vecs.push_back(mk(0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0));
      vecs.push_back(mk(0, 3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0));
      vecs.push_back(mk(0, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0));
      vecs.push_back(mk(0, 3'b101, 32'h1, 32'hFFFFFFFF, 32'h1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b110, 32'h0, 32'h1, 32'hFFFFFFFF, 0, 0, 0));
`ifdef ALU_SAT_EN
      vecs.push_back(mk(0, 3'b010, 32'h80000000, 32'h80000000, 32'h80000000, 0, 1, 1));
`else
      vecs.push_back(mk(0, 3'b010, 32'h80000000, 32'h80000000, 32'h0, 1, 1, 1));
`endif
      // reset asserted mid-stream, then traffic resumes
      vecs.push_back(mk(1, 3'b001, 32'h12345678, 32'h1, 32'h0, 1, 0, 0));
      vecs.push_back(mk(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 0, 0));
      vecs.push_back(mk(0, 3'b010, 32'h00000003, 32'h00000004, 32'h7, 0, 0, 0));

      n = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         step(n, vecs[i]);
         n++;
      end

      for (int i = 0; i < 300; i++) begin
         v.rst = ($urandom_range(0, 24) == 0);
         v.op  = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: v.a = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
            1: v.a = 32'($urandom_range(0, 3));
            default: v.a = $urandom;
         endcase
         v.b = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
         v.e = model(v.rst, v.op, v.a, v.b);
         step(n, v);
         n++;
      end

      @(negedge clk);
      if (sb.size() > 0) compare(n);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
